pixie_dp_front_end: RTL and testbench
=====================================

Name: pixie_dp_front_end

Overview:
- CDP1861 (Pixie) CPU-side front end.
- Tracks 1861 line and machine-cycle timing from CPU TPB strobes, and raises DMA-out requests, INT and EFx toward the 1802 core.
- Captures each DMA-out byte into the dual-port framebuffer write port, at address {row[6:0], byte[2:0]}; this is the layout the display back end scans out.
- Sits between the CPU core and the framebuffer RAM.

Parameters:
cycles_per_line, 14, machine cycles per scan line (112 pixels / 8)
lines_per_frame, 262, lines per frame
active_start_line, 64, first line that takes DMA data
active_lines, 128, number of DMA lines (framebuffer rows 0..127)
dma_start_cycle, 2, first machine cycle of the per-line DMA request window (window is 8 cycles)
int_lines, 2, INT asserted on lines [active_start_line-int_lines, active_start_line-1]
efx_lines, 4, EFx asserted for this many lines before the active area and for this many lines ending at its last line

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tpb  in  1  one-clk strobe at end of each CPU machine cycle
sc  in  2  CPU state code (2'b10 = DMA), sampled with tpb
cpu_data  in  8  CPU data bus, sampled on tpb during a DMA cycle
disp_on  in  1  one-clk strobe (INP 1 decode): enable display
disp_off  in  1  one-clk strobe (OUT 1 decode): disable display
dma_out_req  out  1  DMA-out request to CPU
int_req  out  1  interrupt request to CPU (active high)
efx  out  1  EF1 flag to CPU (active high)
display_enabled  out  1  current display enable state
fb_write_en  out  1  framebuffer write strobe
fb_write_addr  out  10  framebuffer write address {row[6:0], byte[2:0]}
fb_write_data  out  8  framebuffer write data

Behaviour:
- Interface convention: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: all counters = 0, display_enabled = 0, and every output = 0.
- A reset asserted mid-frame or mid-DMA abandons the line; no write is issued for a tpb that coincides with reset.
- mc_cnt (4 bits) advances only on tpb and wraps from cycles_per_line-1 to 0. On that wrap, line_cnt (9 bits) advances and wraps from lines_per_frame-1 to 0.
- active_line = line_cnt in [active_start_line, active_start_line+active_lines-1].
- Row index = line_cnt - active_start_line, truncated to 7 bits.
- dma_out_req is registered: 1 when display_enabled, active_line, and mc_cnt in [dma_start_cycle, dma_start_cycle+7]. It updates the clk after the tpb that changes mc_cnt.
- byte_cnt (3 bits plus a done flag) clears on every line wrap.
- DMA capture: on tpb with sc==2'b10, active_line, display_enabled and done==0:
  - next clk: fb_write_en=1 for exactly one clk, fb_write_addr={row, byte_cnt}, fb_write_data=cpu_data as sampled on that tpb (1-clk latency);
  - byte_cnt then increments; done sets after byte 7.
- DMA cycles after done, outside the active lines, or while the display is disabled produce no write.
- int_req = display_enabled && line_cnt in the INT window. It is cleared immediately when disp_off is taken.
- efx = line_cnt in [active_start_line-efx_lines, active_start_line-1] or in [active_start_line+active_lines-efx_lines, active_start_line+active_lines-1]. It is independent of display_enabled.
- Display enable:
  - disp_on sets display_enabled; disp_off clears it; if both arrive in the same clk, disp_off wins.
  - The change takes effect from the next clk for request and INT decisions.
  - A DMA tpb in the same clk as disp_off is still written.
- Counters advance only on tpb, so if tpb never arrives the outputs hold.
- Width rules: all compares are unsigned at counter width; parameters must satisfy active_start_line >= efx_lines, and dma_start_cycle+8 <= cycles_per_line.

Decomposition:
- Shared package pixie_pkg holds:
  - SC_DMA = 2'b10;
  - the framebuffer address width (10) and row/byte field widths;
  - default timing constants, also used by pixie_dp_back_end.
- One natural sub-module, pixie_line_timer: tpb-driven mc_cnt/line_cnt, with a line_wrap strobe and decoded active/int/efx windows.
- The DMA capture and enable logic stay in the top.

Test Plan:
- Reset, then 14*262 tpb pulses with no disp_on: dma_out_req and int_req stay 0; efx high on lines 60-63 and 188-191 only; mc_cnt/line_cnt return to 0/0.
- disp_on, run to line 62: int_req=1 on lines 62-63 and 0 on line 64. On line 64, dma_out_req=1 for mc 2..9.
- Feed 8 DMA cycles on line 64 with data 0x01..0x08: writes to addr 0x000..0x007 with data 0x01..0x08, each one clk after its tpb.
- Feed 10 DMA cycles on line 191: writes only to 0x3F8..0x3FF; cycles 9 and 10 are ignored.
- disp_on and disp_off in the same clk during line 62: display_enabled=0 and int_req=0 next clk. A coincident DMA tpb on line 100 with disp_off is still written to row 36 (addr 0x120+byte).
- Assert reset after byte 3 of line 70: no further writes; all outputs 0; after release, line_cnt=0 and display_enabled=0.

Source files
------------

// File: rtl/pixie_pkg.sv
// Shared CDP1861 (Pixie) constants and types for the CPU-side front end and the display back end.
package pixie_pkg;

    localparam logic [1:0] SC_DMA = 2'b10;

    localparam int FB_ADDR_W = 10;
    localparam int ROW_W     = 7;
    localparam int BYTE_W    = 3;

    localparam int MC_W   = 4;
    localparam int LINE_W = 9;

    localparam int CYCLES_PER_LINE   = 14;
    localparam int LINES_PER_FRAME   = 262;
    localparam int ACTIVE_START_LINE = 64;
    localparam int ACTIVE_LINES      = 128;
    localparam int DMA_START_CYCLE   = 2;
    localparam int INT_LINES         = 2;
    localparam int EFX_LINES         = 4;

    typedef logic [MC_W-1:0]   mc_t;
    typedef logic [LINE_W-1:0] line_t;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [BYTE_W-1:0] byte_idx;
    } fb_addr_t;

    function automatic logic line_in_range(line_t v, line_t lo, line_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pixie_dp_front_end_if.sv
// CPU and framebuffer-write signals of the Pixie front end; master is the CPU side, slave the front end.
interface pixie_dp_front_end_if;
    import pixie_pkg::*;

    logic                 tpb;
    logic [1:0]           sc;
    logic [7:0]           cpu_data;
    logic                 disp_on;
    logic                 disp_off;
    logic                 dma_out_req;
    logic                 int_req;
    logic                 efx;
    logic                 display_enabled;
    logic                 fb_write_en;
    logic [FB_ADDR_W-1:0] fb_write_addr;
    logic [7:0]           fb_write_data;

    modport master (
        output tpb, sc, cpu_data, disp_on, disp_off,
        input  dma_out_req, int_req, efx, display_enabled,
        input  fb_write_en, fb_write_addr, fb_write_data
    );

    modport slave (
        input  tpb, sc, cpu_data, disp_on, disp_off,
        output dma_out_req, int_req, efx, display_enabled,
        output fb_write_en, fb_write_addr, fb_write_data
    );

endinterface

// File: rtl/pixie_line_timer.sv
// Machine-cycle and scan-line counters driven by CPU TPB strobes, with decoded timing windows.
module pixie_line_timer
    import pixie_pkg::*;
#(
    parameter int CPL       = CYCLES_PER_LINE,
    parameter int LPF       = LINES_PER_FRAME,
    parameter int ACT_START = ACTIVE_START_LINE,
    parameter int ACT_LINES = ACTIVE_LINES,
    parameter int DMA_START = DMA_START_CYCLE,
    parameter int INT_N     = INT_LINES,
    parameter int EFX_N     = EFX_LINES
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  tpb_i,
    output line_t line_cnt_o,
    output logic  line_wrap_o,
    output logic  active_o,
    output logic  int_win_o,
    output logic  efx_win_o,
    output logic  dma_win_o
);

    localparam mc_t   MC_LAST   = mc_t'(CPL - 1);
    localparam mc_t   DMA_FIRST = mc_t'(DMA_START);
    localparam mc_t   DMA_LAST  = mc_t'(DMA_START + 7);
    localparam line_t LINE_LAST = line_t'(LPF - 1);
    localparam line_t ACT_FIRST = line_t'(ACT_START);
    localparam line_t ACT_LAST  = line_t'(ACT_START + ACT_LINES - 1);
    localparam line_t INT_FIRST = line_t'(ACT_START - INT_N);
    localparam line_t PRE_LAST  = line_t'(ACT_START - 1);
    localparam line_t EFX_FIRST = line_t'(ACT_START - EFX_N);
    localparam line_t EFX_TAIL  = line_t'(ACT_START + ACT_LINES - EFX_N);

    mc_t   mc_q,   mc_d;
    line_t line_q, line_d;

    always_comb begin
        // NOTE: defaults first so every path assigns the next state and no latch is inferred.
        mc_d        = mc_q;
        line_d      = line_q;
        line_wrap_o = 1'b0;
        if (tpb_i) begin
            if (mc_q == MC_LAST) begin
                mc_d        = '0;
                line_wrap_o = 1'b1;
                line_d      = (line_q == LINE_LAST) ? '0 : line_q + 1'b1;
            end else begin
                mc_d = mc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking for all state so every register samples pre-edge values.
        if (reset) begin
            mc_q   <= '0;
            line_q <= '0;
        end else begin
            mc_q   <= mc_d;
            line_q <= line_d;
        end
    end

    assign line_cnt_o = line_q;
    assign active_o   = line_in_range(line_q, ACT_FIRST, ACT_LAST);
    assign int_win_o  = line_in_range(line_q, INT_FIRST, PRE_LAST);
    assign efx_win_o  = line_in_range(line_q, EFX_FIRST, PRE_LAST) ||
                        line_in_range(line_q, EFX_TAIL, ACT_LAST);
    assign dma_win_o  = (mc_q >= DMA_FIRST) && (mc_q <= DMA_LAST);

endmodule

// File: rtl/pixie_dp_front_end.sv
// CDP1861 CPU-side front end: DMA/INT/EFx requests toward the 1802 and DMA-out capture into the framebuffer.
module pixie_dp_front_end
    import pixie_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    pixie_dp_front_end_if.slave  bus
);

    localparam line_t ACT_FIRST = line_t'(ACTIVE_START_LINE);

    line_t             line_cnt;
    logic              line_wrap, active, int_win, efx_win, dma_win;
    logic              en_q, en_d;
    logic              dma_req_q, int_q, efx_q;
    logic              we_q;
    fb_addr_t          addr_q;
    logic [7:0]        data_q;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              done_q, done_d;
    logic              capture;
    logic [ROW_W-1:0]  row;

    pixie_line_timer u_timer (
        .clk         (clk),
        .reset       (reset),
        .tpb_i       (bus.tpb),
        .line_cnt_o  (line_cnt),
        .line_wrap_o (line_wrap),
        .active_o    (active),
        .int_win_o   (int_win),
        .efx_win_o   (efx_win),
        .dma_win_o   (dma_win)
    );

    assign row = ROW_W'(line_cnt - ACT_FIRST);

    // Capture uses the current enable, so a DMA coinciding with disp_off is still written.
    assign capture = bus.tpb && (bus.sc == SC_DMA) && active && en_q && !done_q;

    always_comb begin
        en_d = en_q;
        if (bus.disp_on)  en_d = 1'b1;
        if (bus.disp_off) en_d = 1'b0;

        byte_d = byte_q;
        done_d = done_q;
        if (capture) begin
            byte_d = byte_q + 1'b1;
            done_d = (byte_q == '1);
        end
        if (line_wrap) begin
            byte_d = '0;
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q      <= 1'b0;
            dma_req_q <= 1'b0;
            int_q     <= 1'b0;
            efx_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            byte_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            en_q      <= en_d;
            dma_req_q <= en_d && active && dma_win;
            int_q     <= en_d && int_win;
            efx_q     <= efx_win;
            we_q      <= capture;
            byte_q    <= byte_d;
            done_q    <= done_d;
            if (capture) begin
                addr_q <= '{row: row, byte_idx: byte_q};
                data_q <= bus.cpu_data;
            end
        end
    end

    assign bus.dma_out_req     = dma_req_q;
    assign bus.int_req         = int_q;
    assign bus.efx             = efx_q;
    assign bus.display_enabled = en_q;
    assign bus.fb_write_en     = we_q;
    assign bus.fb_write_addr   = addr_q;
    assign bus.fb_write_data   = data_q;

endmodule

// File: tb/tb_pixie_dp_front_end.sv
// Directed bench for pixie_dp_front_end: frame timing, INT/EFx windows, DMA capture, enable strobes and reset.
module tb_pixie_dp_front_end;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    // Reference state of the 1861 as seen from the CPU side.
    int   mc_m, line_m, byte_m;
    logic done_m, en_m;
    logic last_we;
    logic [9:0] last_addr;
    logic [7:0] last_data;

    pixie_dp_front_end_if bus ();

    pixie_dp_front_end dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic exp_efx(int l);
        return (l >= 60 && l <= 63) || (l >= 188 && l <= 191);
    endfunction

    function automatic logic exp_int(int l, logic en);
        return en && (l == 62 || l == 63);
    endfunction

    function automatic logic exp_dma(int l, int m, logic en);
        return en && (l >= 64 && l <= 191) && (m >= 2 && m <= 9);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        mc_m = 0; line_m = 0; byte_m = 0; done_m = 1'b0; en_m = 1'b0;
    endtask

    // One TPB (optionally DMA, optionally with disp_off), then one idle clock; checks write and status.
    task automatic do_tpb(input logic [1:0] s, input logic [7:0] d, input logic off);
        logic       exp_we;
        logic [9:0] exp_addr;
        exp_we   = (s == 2'b10) && line_m >= 64 && line_m <= 191 && en_m && !done_m;
        exp_addr = 10'((line_m - 64) * 8 + byte_m);
        bus.tpb = 1'b1; bus.sc = s; bus.cpu_data = d; bus.disp_off = off;
        tick();
        bus.tpb = 1'b0; bus.sc = 2'b00; bus.cpu_data = 8'h00; bus.disp_off = 1'b0;
        last_we = bus.fb_write_en; last_addr = bus.fb_write_addr; last_data = bus.fb_write_data;
        tests_run++;
        if (bus.fb_write_en !== exp_we) begin
            tests_failed++;
            $display("FAIL write_en line %0d mc %0d: got %b want %b", line_m, mc_m, bus.fb_write_en, exp_we);
        end
        if (exp_we) begin
            tests_run++;
            if (bus.fb_write_addr !== exp_addr || bus.fb_write_data !== d) begin
                tests_failed++;
                $display("FAIL write_bus line %0d: got addr %h data %h want addr %h data %h",
                         line_m, bus.fb_write_addr, bus.fb_write_data, exp_addr, d);
            end
            done_m = (byte_m == 7);
            byte_m = (byte_m + 1) % 8;
        end
        if (off) en_m = 1'b0;
        mc_m++;
        if (mc_m == 14) begin
            mc_m = 0; line_m = (line_m + 1) % 262; byte_m = 0; done_m = 1'b0;
        end
        tick();
        tests_run++;
        if (bus.fb_write_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_one_clk line %0d mc %0d: got %b want 0", line_m, mc_m, bus.fb_write_en);
        end
        tests_run++;
        if ({bus.dma_out_req, bus.int_req, bus.efx, bus.display_enabled} !==
            {exp_dma(line_m, mc_m, en_m), exp_int(line_m, en_m), exp_efx(line_m), en_m}) begin
            tests_failed++;
            $display("FAIL status line %0d mc %0d: got dma/int/efx/en %b%b%b%b want %b%b%b%b",
                     line_m, mc_m, bus.dma_out_req, bus.int_req, bus.efx, bus.display_enabled,
                     exp_dma(line_m, mc_m, en_m), exp_int(line_m, en_m), exp_efx(line_m), en_m);
        end
    endtask

    task automatic run_to(input int l, input int m);
        int guard;
        guard = 0;
        while (!(line_m == l && mc_m == m) && guard < 3700) begin
            do_tpb(2'b00, 8'h00, 1'b0);
            guard++;
        end
        tests_run++;
        if (guard >= 3700) begin
            tests_failed++;
            $display("FAIL run_to: got line %0d mc %0d want line %0d mc %0d", line_m, mc_m, l, m);
        end
    endtask

    task automatic pulse_disp_on();
        bus.disp_on = 1'b1;
        tick();
        bus.disp_on = 1'b0;
        en_m = 1'b1;
        tests_run++;
        if (bus.display_enabled !== 1'b1) begin
            tests_failed++;
            $display("FAIL disp_on: got %b want 1", bus.display_enabled);
        end
    endtask

    task automatic check_all_zero(input string name);
        tests_run++;
        if ({bus.dma_out_req, bus.int_req, bus.efx, bus.display_enabled, bus.fb_write_en,
             bus.fb_write_addr, bus.fb_write_data} !== 23'd0) begin
            tests_failed++;
            $display("FAIL %s: got dma/int/efx/en/we %b%b%b%b%b addr %h data %h want all 0", name,
                     bus.dma_out_req, bus.int_req, bus.efx, bus.display_enabled, bus.fb_write_en,
                     bus.fb_write_addr, bus.fb_write_data);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.tpb = 1'b0; bus.sc = 2'b00; bus.cpu_data = 8'h00;
        bus.disp_on = 1'b0; bus.disp_off = 1'b0;
        tick(); tick();
        reset = 1'b0;
        reset_model();
        check_all_zero("reset_outputs");
    endtask

    task automatic test_idle_frame();
        for (int i = 0; i < 14 * 262; i++) do_tpb(2'b00, 8'h00, 1'b0);
        tests_run++;
        if (dut.u_timer.mc_q !== 4'd0 || dut.u_timer.line_q !== 9'd0) begin
            tests_failed++;
            $display("FAIL frame_wrap: got mc %0d line %0d want 0 0", dut.u_timer.mc_q, dut.u_timer.line_q);
        end
    endtask

    task automatic test_int_dma_line64();
        pulse_disp_on();
        run_to(62, 1);
        tests_run++;
        if (bus.int_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL int_line62: got %b want 1", bus.int_req);
        end
        run_to(64, 0);
        tests_run++;
        if (bus.int_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL int_line64: got %b want 0", bus.int_req);
        end
        for (int i = 0; i < 8; i++) begin
            do_tpb(2'b10, 8'(i + 1), 1'b0);
            tests_run++;
            if (last_we !== 1'b1 || last_addr !== 10'(i) || last_data !== 8'(i + 1)) begin
                tests_failed++;
                $display("FAIL dma64_byte%0d: got we %b addr %h data %h want 1 %h %h",
                         i, last_we, last_addr, last_data, 10'(i), 8'(i + 1));
            end
        end
    endtask

    task automatic test_dma_line191();
        run_to(191, 0);
        for (int i = 0; i < 10; i++) begin
            do_tpb(2'b10, 8'(8'h40 + i), 1'b0);
            tests_run++;
            if (i < 8) begin
                if (last_we !== 1'b1 || last_addr !== 10'(10'h3F8 + i)) begin
                    tests_failed++;
                    $display("FAIL dma191_byte%0d: got we %b addr %h want 1 %h",
                             i, last_we, last_addr, 10'(10'h3F8 + i));
                end
            end else if (last_we !== 1'b0) begin
                tests_failed++;
                $display("FAIL dma191_extra%0d: got we %b want 0", i, last_we);
            end
        end
    endtask

    task automatic test_disp_both();
        run_to(62, 1);
        tests_run++;
        if (bus.int_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL int_before_both: got %b want 1", bus.int_req);
        end
        bus.disp_on = 1'b1; bus.disp_off = 1'b1;
        tick();
        bus.disp_on = 1'b0; bus.disp_off = 1'b0;
        en_m = 1'b0;
        tests_run++;
        if (bus.display_enabled !== 1'b0 || bus.int_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL disp_both: got en %b int %b want 0 0", bus.display_enabled, bus.int_req);
        end
    endtask

    task automatic test_dma_with_disp_off();
        pulse_disp_on();
        run_to(100, 0);
        do_tpb(2'b10, 8'hA5, 1'b1);
        tests_run++;
        if (last_we !== 1'b1 || last_addr !== 10'h120 || last_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL dma_disp_off: got we %b addr %h data %h want 1 120 a5", last_we, last_addr, last_data);
        end
        do_tpb(2'b10, 8'h5A, 1'b0);
        tests_run++;
        if (last_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL dma_after_off: got we %b want 0", last_we);
        end
    endtask

    task automatic test_reset_mid_dma();
        pulse_disp_on();
        run_to(70, 0);
        for (int i = 0; i < 4; i++) do_tpb(2'b10, 8'(8'hC0 + i), 1'b0);
        tests_run++;
        if (last_addr !== 10'h033 || last_data !== 8'hC3) begin
            tests_failed++;
            $display("FAIL dma70_byte3: got addr %h data %h want 033 c3", last_addr, last_data);
        end
        bus.tpb = 1'b1; bus.sc = 2'b10; bus.cpu_data = 8'hEE;
        reset = 1'b1;
        tick();
        bus.tpb = 1'b0; bus.sc = 2'b00; bus.cpu_data = 8'h00;
        check_all_zero("reset_mid_dma");
        tick();
        reset = 1'b0;
        reset_model();
        check_all_zero("reset_hold");
        tests_run++;
        if (dut.u_timer.line_q !== 9'd0 || bus.display_enabled !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got line %0d en %b want 0 0", dut.u_timer.line_q, bus.display_enabled);
        end
        do_tpb(2'b10, 8'h77, 1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_model();
        test_reset();
        test_idle_frame();
        test_int_dma_line64();
        test_dma_line191();
        test_disp_both();
        test_dma_with_disp_off();
        test_reset_mid_dma();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
